salu_retire: RTL
================

Name: salu_retire

Overview:
- Consumer end of the SALU decode interface: takes the decoded enables and wordsels for one instruction, plus the ALU result, and commits them.
- Commits go to SGPR, EXEC, VCC, M0 and a per-wavefront SCC store. It also resolves SOPP branches and reports instruction completion to the wavefront scheduler.
- Sits between the SALU datapath and the architectural state files. It owns the only SGPR write port used by the SALU.

Parameters:
- WF_COUNT, 40, number of wavefront slots with an SCC bit.
- WFID_W, 6, wavefront id width.

Ports:
- clk in 1 clock
- rst_n in 1 asynchronous active-low reset
- in_valid in 1 instruction offered
- in_ready out 1 block can accept
- in_wfid in WFID_W issuing wavefront
- in_pc in 32 instruction PC
- in_simm16 in 16 branch offset in dwords, signed
- in_sgpr_en in 2 bit0 = low dword write, bit1 = high dword write
- in_sgpr_addr in 9 destination SGPR, low dword
- in_exec_en in 1 EXEC write
- in_exec_wordsel in 2 EXEC dword select
- in_vcc_en in 1 VCC write
- in_vcc_wordsel in 2 VCC dword select
- in_m0_en in 1 M0 write
- in_scc_en in 1 SCC write
- in_exec_sgpr_cpy in 1 saveexec: old EXEC goes to SGPR, result goes to EXEC
- in_branch_on_cc in 6 {execnz, execz, vccnz, vccz, scc1, scc0}; all ones = unconditional
- in_result in 64 ALU result
- in_scc in 1 ALU SCC out
- exec_rd_data in 64 current EXEC of in_wfid, valid while in_valid
- vcc_rd_data in 64 current VCC of in_wfid, valid while in_valid
- sgpr_wr_en out 1 SGPR write request
- sgpr_wr_addr out 9
- sgpr_wr_data out 32
- sgpr_wr_ready in 1 SGPR port accepts
- exec_wr_en out 1
- exec_wr_wordsel out 2
- exec_wr_data out 64
- vcc_wr_en out 1
- vcc_wr_wordsel out 2
- vcc_wr_data out 64
- m0_wr_en out 1
- m0_wr_data out 32
- wr_wfid out WFID_W wavefront for all write strobes
- branch_valid out 1 pulse: branch resolved
- branch_taken out 1
- branch_target out 32
- retire_valid out 1 pulse: instruction fully committed
- retire_wfid out WFID_W

Behaviour:

Reset:
- All outputs are 0; FSM is IDLE; the SCC array is all zero.
- Reset asserted mid-operation abandons any pending SGPR write with no retire.

FSM states: IDLE, COMMIT, SGPR_LO, SGPR_HI.
- in_ready = (state == IDLE).
- Handshake occurs on in_valid & in_ready. All inputs, including exec_rd_data and vcc_rd_data, are captured into registers and the FSM moves to COMMIT.

COMMIT (exactly one cycle):
- exec_wr_en, vcc_wr_en and m0_wr_en pulse when their enables are set, with the captured wordsel.
- exec_wr_data = result. vcc_wr_data = result. m0_wr_data = result[31:0].
- If scc_en: SCC[wfid] <= in_scc at the end of COMMIT.
- Branch evaluation uses the SCC value before this instruction's update:
  - taken = (cc == 6'b111111) | (cc[0] & ~scc) | (cc[1] & scc) | (cc[2] & vcc == 0) | (cc[3] & vcc != 0) | (cc[4] & exec == 0) | (cc[5] & exec != 0).
  - branch_valid pulses iff cc != 0.
  - branch_target = pc + 4 + (sext(simm16) << 2), with 32-bit wrap.
- Next state:
  - sgpr_en[0] set: go to SGPR_LO.
  - sgpr_en == 2'b10: go to SGPR_HI.
  - Otherwise: retire_valid pulses in COMMIT and the FSM returns to IDLE.

SGPR data source:
- src = exec_sgpr_cpy ? captured exec_rd_data : result.

SGPR_LO:
- sgpr_wr_en = 1, addr = sgpr_addr, data = src[31:0].
- Held stable until sgpr_wr_ready.
- On acceptance: go to SGPR_HI if sgpr_en[1], else pulse retire_valid and go to IDLE.

SGPR_HI:
- sgpr_wr_en = 1, data = src[63:32].
- addr = sgpr_en[0] ? sgpr_addr + 1 : sgpr_addr, 9-bit wrap.
- On acceptance: pulse retire_valid and go to IDLE.

Latency and throughput:
- Minimum latency is handshake to retire = 1 cycle (COMMIT).
- A 64-bit SGPR write with ready held high retires 3 cycles after the handshake.
- Peak throughput is 1 instruction per 2 cycles.

Other rules:
- in_wfid >= WF_COUNT: no SCC update, and branches read SCC as 0.
- The retire pulse never coincides with in_ready in the same cycle.
- retire_wfid and wr_wfid equal the captured wfid throughout.

Test Plan:
- s_add_u32 into SGPR 5: sgpr_en=01, result=0x1_0000_0003, scc_en=1, in_scc=1, ready=1 -> one write of 0x00000003 to addr 5 in SGPR_LO; SCC[wfid]=1; retire 2 cycles after handshake.
- s_and_saveexec_b64 into SGPR 10: sgpr_en=11, exec_sgpr_cpy=1, exec_rd=0xFFFF_0000_0000_FFFF, result=0x0F, exec wordsel=11 -> exec_wr_data=0x0F in COMMIT; SGPR 10 gets 0x0000FFFF, then SGPR 11 gets 0xFFFF0000.
- s_cbranch_scc1 after SCC was set to 1: pc=0x100, simm16=0xFFFE -> branch_valid=1, taken=1, target=0x0FC. Same with SCC=0 -> taken=0.
- s_branch at pc=0xFFFFFFF8, simm16=1 -> taken=1, target=0x00000000 (wrap).
- 64-bit SGPR write with sgpr_wr_ready low for 4 cycles -> addr/data held stable; in_ready stays 0; no retire until both dwords are accepted.
- rst_n asserted while in SGPR_HI -> all outputs 0 immediately; SCC array cleared; in_ready=1 after release; no retire_valid.

Source files
------------

// File: rtl/salu_retire_if.sv
// Decoded SALU instruction bundle plus operand readback, offered to the retire stage.
// Producer holds everything stable while in_valid is high and in_ready is low.
interface salu_retire_if #(
   parameter int WFID_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [WFID_W-1:0] in_wfid;
   logic [31:0]       in_pc;
   logic [15:0]       in_simm16;
   logic [1:0]        in_sgpr_en;
   logic [8:0]        in_sgpr_addr;
   logic              in_exec_en;
   logic [1:0]        in_exec_wordsel;
   logic              in_vcc_en;
   logic [1:0]        in_vcc_wordsel;
   logic              in_m0_en;
   logic              in_scc_en;
   logic              in_exec_sgpr_cpy;
   logic [5:0]        in_branch_on_cc;
   logic [63:0]       in_result;
   logic              in_scc;
   logic [63:0]       exec_rd_data;
   logic [63:0]       vcc_rd_data;

   modport master (
      output in_valid, in_wfid, in_pc, in_simm16, in_sgpr_en, in_sgpr_addr,
             in_exec_en, in_exec_wordsel, in_vcc_en, in_vcc_wordsel, in_m0_en,
             in_scc_en, in_exec_sgpr_cpy, in_branch_on_cc, in_result, in_scc,
             exec_rd_data, vcc_rd_data,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_wfid, in_pc, in_simm16, in_sgpr_en, in_sgpr_addr,
             in_exec_en, in_exec_wordsel, in_vcc_en, in_vcc_wordsel, in_m0_en,
             in_scc_en, in_exec_sgpr_cpy, in_branch_on_cc, in_result, in_scc,
             exec_rd_data, vcc_rd_data,
      output in_ready
   );
endinterface

// File: rtl/salu_retire.sv
// SALU retire: commits EXEC/VCC/M0/SCC and resolves branches 1 cycle after accept, then drains
// up to two SGPR dwords; stalls on sgpr_wr_ready and accepts nothing until the instruction retires.
module salu_retire #(
   parameter int WF_COUNT = 40,
   parameter int WFID_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   salu_retire_if.slave      dec,
   output logic              sgpr_wr_en,
   output logic [8:0]        sgpr_wr_addr,
   output logic [31:0]       sgpr_wr_data,
   input  logic              sgpr_wr_ready,
   output logic              exec_wr_en,
   output logic [1:0]        exec_wr_wordsel,
   output logic [63:0]       exec_wr_data,
   output logic              vcc_wr_en,
   output logic [1:0]        vcc_wr_wordsel,
   output logic [63:0]       vcc_wr_data,
   output logic              m0_wr_en,
   output logic [31:0]       m0_wr_data,
   output logic [WFID_W-1:0] wr_wfid,
   output logic              branch_valid,
   output logic              branch_taken,
   output logic [31:0]       branch_target,
   output logic              retire_valid,
   output logic [WFID_W-1:0] retire_wfid
);
   typedef enum logic [1:0] {IDLE, COMMIT, SGPR_LO, SGPR_HI} state_t;

   state_t              state_q, state_d;
   logic [WFID_W-1:0]   wfid_q;
   logic [31:0]         pc_q;
   logic [15:0]         simm_q;
   logic [1:0]          sgpr_en_q;
   logic [8:0]          sgpr_addr_q;
   logic                exec_en_q, vcc_en_q, m0_en_q, scc_en_q, cpy_q, scc_in_q;
   logic [1:0]          exec_ws_q, vcc_ws_q;
   logic [5:0]          cc_q;
   logic [63:0]         result_q, exec_q, vcc_q;
   logic [WF_COUNT-1:0] scc_q;

   logic                scc_cur, taken;
   logic [63:0]         src;
   logic [8:0]          hi_addr;
   logic [31:0]         target;

   assign dec.in_ready = (state_q == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wfid_q      <= '0;
         pc_q        <= '0;
         simm_q      <= '0;
         sgpr_en_q   <= '0;
         sgpr_addr_q <= '0;
         exec_en_q   <= 1'b0;
         vcc_en_q    <= 1'b0;
         m0_en_q     <= 1'b0;
         scc_en_q    <= 1'b0;
         cpy_q       <= 1'b0;
         scc_in_q    <= 1'b0;
         exec_ws_q   <= '0;
         vcc_ws_q    <= '0;
         cc_q        <= '0;
         result_q    <= '0;
         exec_q      <= '0;
         vcc_q       <= '0;
         scc_q       <= '0;
      end else begin
         state_q <= state_d;
         if (dec.in_valid && dec.in_ready) begin
            wfid_q      <= dec.in_wfid;
            pc_q        <= dec.in_pc;
            simm_q      <= dec.in_simm16;
            sgpr_en_q   <= dec.in_sgpr_en;
            sgpr_addr_q <= dec.in_sgpr_addr;
            exec_en_q   <= dec.in_exec_en;
            vcc_en_q    <= dec.in_vcc_en;
            m0_en_q     <= dec.in_m0_en;
            scc_en_q    <= dec.in_scc_en;
            cpy_q       <= dec.in_exec_sgpr_cpy;
            scc_in_q    <= dec.in_scc;
            exec_ws_q   <= dec.in_exec_wordsel;
            vcc_ws_q    <= dec.in_vcc_wordsel;
            cc_q        <= dec.in_branch_on_cc;
            result_q    <= dec.in_result;
            exec_q      <= dec.exec_rd_data;
            vcc_q       <= dec.vcc_rd_data;
         end
         // Out-of-range wavefront ids match no slot, so they never touch the SCC store.
         if (state_q == COMMIT && scc_en_q) begin
            for (int i = 0; i < WF_COUNT; i++) begin
               if (wfid_q == WFID_W'(i)) scc_q[i] <= scc_in_q;
            end
         end
      end
   end

   always_comb begin
      scc_cur = 1'b0;
      for (int i = 0; i < WF_COUNT; i++) begin
         if (wfid_q == WFID_W'(i)) scc_cur = scc_q[i];
      end
   end

   assign taken = (&cc_q) | (cc_q[0] & ~scc_cur) | (cc_q[1] & scc_cur)
                | (cc_q[2] & (vcc_q == 64'd0)) | (cc_q[3] & (vcc_q != 64'd0))
                | (cc_q[4] & (exec_q == 64'd0)) | (cc_q[5] & (exec_q != 64'd0));
   assign target  = pc_q + 32'd4 + {{14{simm_q[15]}}, simm_q, 2'b00};
   assign src     = cpy_q ? exec_q : result_q;
   assign hi_addr = sgpr_en_q[0] ? sgpr_addr_q + 9'd1 : sgpr_addr_q;

   always_comb begin
      state_d         = state_q;
      sgpr_wr_en      = 1'b0;
      sgpr_wr_addr    = '0;
      sgpr_wr_data    = '0;
      exec_wr_en      = 1'b0;
      exec_wr_wordsel = '0;
      exec_wr_data    = '0;
      vcc_wr_en       = 1'b0;
      vcc_wr_wordsel  = '0;
      vcc_wr_data     = '0;
      m0_wr_en        = 1'b0;
      m0_wr_data      = '0;
      branch_valid    = 1'b0;
      branch_taken    = 1'b0;
      branch_target   = '0;
      retire_valid    = 1'b0;
      wr_wfid         = wfid_q;
      retire_wfid     = wfid_q;
      case (state_q)
         IDLE: begin
            if (dec.in_valid) state_d = COMMIT;
         end
         COMMIT: begin
            exec_wr_en      = exec_en_q;
            exec_wr_wordsel = exec_ws_q;
            exec_wr_data    = result_q;
            vcc_wr_en       = vcc_en_q;
            vcc_wr_wordsel  = vcc_ws_q;
            vcc_wr_data     = result_q;
            m0_wr_en        = m0_en_q;
            m0_wr_data      = result_q[31:0];
            branch_valid    = |cc_q;
            branch_taken    = (|cc_q) & taken;
            branch_target   = (|cc_q) ? target : 32'd0;
            if (sgpr_en_q[0]) begin
               state_d = SGPR_LO;
            end else if (sgpr_en_q[1]) begin
               state_d = SGPR_HI;
            end else begin
               retire_valid = 1'b1;
               state_d      = IDLE;
            end
         end
         SGPR_LO: begin
            sgpr_wr_en   = 1'b1;
            sgpr_wr_addr = sgpr_addr_q;
            sgpr_wr_data = src[31:0];
            if (sgpr_wr_ready) begin
               if (sgpr_en_q[1]) begin
                  state_d = SGPR_HI;
               end else begin
                  retire_valid = 1'b1;
                  state_d      = IDLE;
               end
            end
         end
         SGPR_HI: begin
            sgpr_wr_en   = 1'b1;
            sgpr_wr_addr = hi_addr;
            sgpr_wr_data = src[63:32];
            if (sgpr_wr_ready) begin
               retire_valid = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule
